// File: rtl/arith_unit_arbiter_if.sv
// Request/grant/result bundle between two requesters and the shared arithmetic unit arbiter.
// The master modport belongs to the requester side and the slave modport to the arbiter.
interface arith_unit_arbiter_if;
  logic       req0;
  logic       req1;
  logic       op0;
  logic       op1;
  logic [1:0] a0;
  logic [1:0] b0;
  logic [1:0] a1;
  logic [1:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [3:0] result;
  logic       busy;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/arith_unit_arbiter.sv
// Round-robin sharing of one 2-bit add/multiply unit between two requesters; gnt one cycle after the IDLE sample, done+result the cycle after.
// No backpressure: a requester holds req until its done pulse, and waiting requests are sampled again in the next IDLE cycle.
module arith_unit_arbiter (
  input  logic                       clk,
  input  logic                       rst,
  arith_unit_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [1:0] ua;
  logic [1:0] ub;
  logic       uop;
  logic       owner;
  logic       last;
  logic [3:0] result_q;

  logic       any_req;
  logic       winner;
  logic       capture;
  logic [3:0] unit_add;
  logic [3:0] unit_mul;

  // arithmaticUnit datapath: both results are always available from the latched operands
  assign unit_add = {1'b0, ({1'b0, ua} + {1'b0, ub})};
  assign unit_mul = {2'b00, ua} * {2'b00, ub};

  always_comb begin
    any_req = bus.req0 | bus.req1;
    // on a tie the requester that was not served last wins
    winner  = (bus.req0 && bus.req1) ? ~last : bus.req1;
    capture = (state == IDLE) && any_req;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ua       <= 2'b00;
      ub       <= 2'b00;
      uop      <= 1'b0;
      owner    <= 1'b0;
      last     <= 1'b1;
      result_q <= 4'b0000;
    end else begin
      if (capture) begin
        ua    <= winner ? bus.a1  : bus.a0;
        ub    <= winner ? bus.b1  : bus.b0;
        uop   <= winner ? bus.op1 : bus.op0;
        owner <= winner;
        last  <= winner;
      end
      if (state == EXEC) begin
        result_q <= uop ? unit_mul : unit_add;
      end
    end
  end

  assign bus.gnt0   = (state == EXEC) && !owner;
  assign bus.gnt1   = (state == EXEC) &&  owner;
  assign bus.done0  = (state == RESP) && !owner;
  assign bus.done1  = (state == RESP) &&  owner;
  assign bus.busy   = (state != IDLE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_arith_unit_arbiter.sv
// Bench for arith_unit_arbiter: transaction-scheduling reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized request/reset phase.
module tb_arith_unit_arbiter;

  logic clk = 1'b0;
  logic rst;
  arith_unit_arbiter_if bus();

  arith_unit_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       d0;
    logic       d1;
    logic       busy;
    logic [3:0] res;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   chk_en   = 0;
  exp_t cur      = '0;
  exp_t sched[$];

  logic [8:0] outv;
  assign outv = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.result};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Reference model: a sampled request books three future cycles (grant, done, idle).
  initial begin : model
    bit   last_m;
    bit   w;
    int   a, b, r;
    bit   op;
    logic [3:0] held;
    exp_t e;
    last_m = 1'b1;
    held   = 4'd0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        sched.delete();
        last_m = 1'b1;
        held   = 4'd0;
        cur    = '0;
      end else begin
        if (sched.size() == 0 && (bus.req0 || bus.req1)) begin
          w      = (bus.req0 && bus.req1) ? !last_m : bus.req1;
          last_m = w;
          op = w ? bus.op1 : bus.op0;
          a  = w ? int'(bus.a1) : int'(bus.a0);
          b  = w ? int'(bus.b1) : int'(bus.b0);
          r  = op ? a * b : a + b;
          e = '0; e.g0 = !w; e.g1 = w; e.busy = 1'b1; e.res = held;
          sched.push_back(e);
          held = r[3:0];
          e = '0; e.d0 = !w; e.d1 = w; e.busy = 1'b1; e.res = held;
          sched.push_back(e);
          e = '0; e.res = held;
          sched.push_back(e);
        end
        if (sched.size() != 0) cur = sched.pop_front();
        else begin
          cur = '0;
          cur.res = held;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        if (outv !== cur) begin
          failures++;
          $display("FAIL outputs cycle=%0d actual=%b required=%b", cyc, outv, cur);
        end
      end
    end
  end

  task automatic set_req(input bit p, input bit r, input bit op, input logic [1:0] a, input logic [1:0] b);
    if (!p) begin bus.req0 = r; bus.op0 = op; bus.a0 = a; bus.b0 = b; end
    else    begin bus.req1 = r; bus.op1 = op; bus.a1 = a; bus.b1 = b; end
  endtask

  task automatic drop(input bit p);
    if (!p) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in the next IDLE cycle.
  task automatic do_single(input string name, input bit p, input bit op,
                           input logic [1:0] a, input logic [1:0] b, input logic [3:0] res);
    set_req(p, 1'b1, op, a, b);
    @(negedge clk);
    check({name, "_gnt"}, {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy},
          p ? 5'b01001 : 5'b10001);
    @(negedge clk);
    check({name, "_done"}, {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy},
          p ? 5'b00011 : 5'b00101);
    check({name, "_result"}, bus.result, res);
    drop(p);
    @(negedge clk);
    check({name, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin : stim
    logic [12:0] g0v, g1v;
    bit rq [2];
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_state", outv, 9'd0);
    rst = 1'b0;
    @(negedge clk);

    do_single("single_add", 0, 0, 2'd3, 2'd3, 4'b0110);
    do_single("single_mul", 1, 1, 2'd3, 2'd3, 4'b1001);

    // tie right after reset: requester 0 first
    do_reset();
    set_req(0, 1, 0, 2'd2, 2'd1);
    set_req(1, 1, 1, 2'd2, 2'd2);
    @(negedge clk); check("tie_gnt0_c1", {bus.gnt0, bus.gnt1}, 2'b10);
    @(negedge clk); check("tie_done0_c2", {bus.done0, bus.done1, bus.result}, 6'b10_0011);
    @(negedge clk);
    @(negedge clk); check("tie_gnt1_c4", {bus.gnt0, bus.gnt1}, 2'b01);
    @(negedge clk); check("tie_done1_c5", {bus.done0, bus.done1, bus.result}, 6'b01_0100);
    drop(0); drop(1);
    @(negedge clk);

    // fairness: both held for 12 cycles
    do_reset();
    set_req(0, 1, 0, 2'd1, 2'd2);
    set_req(1, 1, 1, 2'd3, 2'd1);
    g0v = '0; g1v = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      g0v[i] = bus.gnt0;
      g1v[i] = bus.gnt1;
    end
    check("fair_gnt0_cycles", g0v, 13'b0_0000_1000_0010);
    check("fair_gnt1_cycles", g1v, 13'b0_0100_0001_0000);
    drop(0); drop(1);
    @(negedge clk);

    // operand isolation: change inputs during the grant cycle
    set_req(0, 1, 1, 2'd3, 2'd2);
    @(negedge clk);
    check("iso_gnt0", bus.gnt0, 1'b1);
    set_req(0, 1, 0, 2'd0, 2'd0);
    @(negedge clk);
    check("iso_result", {bus.done0, bus.result}, 5'b1_0110);
    drop(0);
    @(negedge clk);

    // reset during EXEC aborts the operation
    set_req(0, 1, 0, 2'd3, 2'd2);
    @(negedge clk);
    check("abort_gnt0", bus.gnt0, 1'b1);
    rst = 1'b1;
    drop(0);
    @(negedge clk);
    check("abort_outputs", outv, 9'd0);
    rst = 1'b0;
    do_single("after_abort_add", 1, 0, 2'd1, 2'd1, 4'b0010);

    // randomized requests, operand churn and occasional resets
    rq[0] = 0; rq[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[p]) begin
          if ($urandom_range(0, 3) == 0) begin
            rq[p] = 1;
            set_req(p[0], 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
          end
        end else begin
          if (((p == 0) ? bus.done0 : bus.done1) && $urandom_range(0, 4) != 0) begin
            rq[p] = 0;
            drop(p[0]);
          end else if ($urandom_range(0, 3) == 0) begin
            set_req(p[0], 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
          end
        end
      end
      rst = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    drop(0); drop(1);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
